// File: rtl/conv_feed_sequencer_if.sv
// Operand-memory read ports plus the serial systolic-array feed, bundled.
//   master : the sequencer (drives read enables/addresses and the array feed)
//   slave  : memories + array (return read data, consume the feed)
// Signals:
//   img_ren/img_addr/img_rdata : image memory, data valid the cycle after ren
//   ker_ren/ker_addr/ker_rdata : kernel memory, data valid the cycle after ren
//   sa_rst                     : array clear pulse
//   sa_a/sa_w/sa_v             : activation, weight, sample-valid
interface conv_feed_sequencer_if #(
  parameter int DW  = 8,
  parameter int IAW = 4,
  parameter int KAW = 2
);
  logic           img_ren;
  logic [IAW-1:0] img_addr;
  logic [DW-1:0]  img_rdata;
  logic           ker_ren;
  logic [KAW-1:0] ker_addr;
  logic [DW-1:0]  ker_rdata;
  logic           sa_rst;
  logic [DW-1:0]  sa_a;
  logic [DW-1:0]  sa_w;
  logic           sa_v;

  modport master (
    output img_ren, img_addr, ker_ren, ker_addr, sa_rst, sa_a, sa_w, sa_v,
    input  img_rdata, ker_rdata
  );

  modport slave (
    input  img_ren, img_addr, ker_ren, ker_addr, sa_rst, sa_a, sa_w, sa_v,
    output img_rdata, ker_rdata
  );
endinterface

// File: rtl/conv_feed_sequencer.sv
// Streams one convolution job into the systolic array: clears the array,
// walks the image in reverse row-major order with the kernel-masked weight
// alongside, drains zeros, then pulses done.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : job request, only looked at in IDLE
//   busy     : job in progress (CLR through DRAIN)
//   done     : one-cycle completion pulse (DONE state)
//   bus      : memory read ports and array feed (master side)
//
// state  | meaning
// IDLE   | waiting for start
// CLR    | sa_rst pulse to the array
// FEED   | one image (and maybe kernel) read per cycle, N steps
// DRAIN  | last sample lands, then DRAIN zero cycles
// DONE   | done pulse, busy low
module conv_feed_sequencer #(
  parameter int IMG_H = 3,
  parameter int IMG_W = 3,
  parameter int K     = 2,
  parameter int DW    = 8,
  parameter int DRAIN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  conv_feed_sequencer_if.master bus
);
  localparam int N   = IMG_H * IMG_W;
  localparam int IAW = (N > 1) ? $clog2(N) : 1;
  localparam int KAW = (K * K > 1) ? $clog2(K * K) : 1;
  localparam int IW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int JW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int DCW = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t         state;
  logic [IW-1:0]  i;
  logic [JW-1:0]  j;
  logic [DCW-1:0] drain_cnt;
  logic           img_ren;
  logic [IAW-1:0] img_addr;
  logic           ker_ren;
  logic [KAW-1:0] ker_addr;
  logic           sa_rst;
  logic           sa_v;
  logic           kin_q;   // kernel was in range for the read landing now

  logic           wrap_j;
  logic           last_step;
  logic [IW-1:0]  ni;
  logic [JW-1:0]  nj;
  logic           nkin;
  logic [KAW-1:0] nkaddr;

  assign wrap_j    = (j == JW'(IMG_W - 1));
  assign last_step = wrap_j && (i == IW'(IMG_H - 1));
  assign ni        = wrap_j ? i + IW'(1) : i;
  assign nj        = wrap_j ? '0 : j + JW'(1);
  assign nkin      = (int'(ni) < K) && (int'(nj) < K);
  // Only meaningful when nkin; masked to 0 otherwise.
  assign nkaddr    = KAW'((K - 1 - int'(ni)) * K + (K - 1 - int'(nj)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      i         <= '0;
      j         <= '0;
      drain_cnt <= '0;
      img_ren   <= 1'b0;
      img_addr  <= '0;
      ker_ren   <= 1'b0;
      ker_addr  <= '0;
      sa_rst    <= 1'b0;
      sa_v      <= 1'b0;
      kin_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Read data returns one cycle after the request; the valid and
      // kernel-mask flags follow it through this single pipeline stage.
      sa_v   <= img_ren;
      kin_q  <= ker_ren;
      sa_rst <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_CLR;
            sa_rst <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_CLR: begin
          // Step 0 always hits the kernel's far corner since K >= 1.
          state    <= S_FEED;
          i        <= '0;
          j        <= '0;
          img_ren  <= 1'b1;
          img_addr <= IAW'(N - 1);
          ker_ren  <= 1'b1;
          ker_addr <= KAW'(K * K - 1);
        end
        S_FEED: begin
          if (last_step) begin
            state     <= S_DRAIN;
            i         <= '0;
            j         <= '0;
            img_ren   <= 1'b0;
            img_addr  <= '0;
            ker_ren   <= 1'b0;
            ker_addr  <= '0;
            drain_cnt <= DCW'(DRAIN);
          end else begin
            i        <= ni;
            j        <= nj;
            // Reverse row-major walk is a plain down-count of the image address.
            img_addr <= img_addr - IAW'(1);
            ker_ren  <= nkin;
            ker_addr <= nkin ? nkaddr : '0;
          end
        end
        S_DRAIN: begin
          // First DRAIN cycle still carries the final sample.
          if (drain_cnt == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.img_ren  = img_ren;
  assign bus.img_addr = img_addr;
  assign bus.ker_ren  = ker_ren;
  assign bus.ker_addr = ker_addr;
  assign bus.sa_rst   = sa_rst;
  assign bus.sa_v     = sa_v;
  assign bus.sa_a     = sa_v ? bus.img_rdata : '0;
  assign bus.sa_w     = (sa_v && kin_q) ? bus.ker_rdata : '0;
endmodule
